pci_initiator: RTL and testbench
================================

PCI_INITIATOR -- requirements
Module: pci_initiator

Interface
REQ-001 Parameter CMD_READ, 4'b0001, C_BE value driven in the address phase of a read.
REQ-002 Parameter CMD_WRITE, 4'b0010, C_BE value driven in the address phase of a write.
REQ-003 Parameter DEVSEL_TIMEOUT, 4, data-phase sampling edges allowed before DEVSEL must be seen low; legal range 1..7.
REQ-004 Port CLK  input  1  sole clock; all state updates on the rising edge.
REQ-005 Port RST  input  1  reset, synchronous and active-high.
REQ-006 Port ADDR_DATA  inout  32  multiplexed PCI address/data bus, tri-stated when not driven.
REQ-007 Port C_BE  output  4  command in the address phase, active-high byte enables in data phases.
REQ-008 Port FRAME, IRDY  output  1 each  active-low PCI framing and initiator-ready.
REQ-009 Port TRDY, DEVSEL  input  1 each  active-low target-ready and device-select.
REQ-010 Port req  input  1  start request, sampled only in IDLE.
REQ-011 Port req_wr  input  1  1 = write, 0 = read.
REQ-012 Port req_addr  input  32  transaction start address.
REQ-013 Port req_len  input  4  number of data phases minus one (1..16 phases).
REQ-014 Port wr_data, wr_be, wr_valid  input  32, 4, 1  first-word-fall-through write-data source.
REQ-015 Port wr_pop  output  1  pop strobe for the write-data source.
REQ-016 Port rd_data, rd_valid  output  32, 1  read word and its one-cycle qualifier.
REQ-017 Port busy, done, error  output  1 each  transaction active, end pulse, master-abort flag.

Function
REQ-018 The FSM SHALL have exactly five states: IDLE, ADDR, DATA, ABORT and TURN.
REQ-019 IDLE SHALL drive FRAME=1, IRDY=1, ADDR_DATA=Z, C_BE=4'b0000 and busy=0; req=1 on an edge SHALL latch req_wr, req_addr and req_len and go to ADDR.
REQ-020 ADDR SHALL last one cycle, driving FRAME=0, IRDY=1, ADDR_DATA=latched address and C_BE=CMD_WRITE or CMD_READ, then go to DATA.
REQ-021 A 5-bit remaining-phase counter SHALL load req_len+1 at the start and decrement on every completed phase.
REQ-022 In DATA, FRAME SHALL be 0 while remaining>1 and 1 while remaining==1, so FRAME is high during the final phase.
REQ-023 In a read DATA cycle, IRDY SHALL be 0, C_BE=4'b1111 and ADDR_DATA=Z.
REQ-024 In a write DATA cycle, ADDR_DATA SHALL equal wr_data and C_BE SHALL equal wr_be, driven combinationally.
REQ-025 In a write DATA cycle, IRDY SHALL be the inverse of wr_valid, so an initiator wait state is inserted while wr_valid=0.
REQ-026 A phase SHALL complete on an edge where IRDY=0, TRDY=0 and DEVSEL=0; TRDY=0 with DEVSEL=1 SHALL NOT complete a phase.
REQ-027 wr_pop SHALL equal the completion condition during write DATA cycles and SHALL be 0 otherwise.
REQ-028 On each read completion edge, rd_data SHALL register ADDR_DATA and rd_valid SHALL pulse high for the next cycle only.
REQ-029 Completion of the phase with remaining==1 SHALL move the FSM to TURN.
REQ-030 A DEVSEL-seen flag SHALL set on the first edge DEVSEL=0 is sampled in DATA; a 3-bit timeout counter SHALL count DATA edges while the flag is clear.
REQ-031 When the timeout counter reaches DEVSEL_TIMEOUT with DEVSEL=1, the FSM SHALL go to ABORT; if DEVSEL=0 is sampled on that same edge, the flag sets and no abort occurs.
REQ-032 ABORT SHALL last one cycle with FRAME=1, IRDY=1, ADDR_DATA=Z and error=1, then go to TURN; no wr_pop or rd_valid SHALL occur after entry to ABORT.
REQ-033 TURN SHALL last one cycle with FRAME=1, IRDY=1, ADDR_DATA=Z and done=1, then go to IDLE.
REQ-034 busy SHALL be 1 in ADDR, DATA, ABORT and TURN.
REQ-035 req SHALL be ignored outside IDLE, and a req held high during TURN SHALL start a new transaction only from the following IDLE cycle (minimum one idle cycle between transactions).

Reset
REQ-036 RST=1 on any edge SHALL force IDLE on the next cycle from any state, including mid-burst.
REQ-037 Reset SHALL clear all counters and flags and leave FRAME=1, IRDY=1, ADDR_DATA=Z, C_BE=0, and busy, done, error, rd_valid and wr_pop all 0.
REQ-038 Reset SHALL produce no done or error pulse.

Verification
REQ-039 Single write: req_wr=1, addr=32'h0000_0000, len=0, wr_data=32'hDEAD_BEEF, be=4'hF, target DEVSEL/TRDY low at the first DATA edge -> address phase with C_BE=4'b0010; one data phase with FRAME=1, IRDY=0; wr_pop for one cycle; done one cycle later.
REQ-040 Read burst: len=3, target returns 1,2,3,4 with TRDY=1 for 2 cycles before word 3 -> four rd_valid pulses carrying 1..4 in order; FRAME high only during the 4th phase; IRDY held 0 through the wait.
REQ-041 Write with source stall: len=1, wr_valid=0 for 3 cycles before word 2 -> IRDY=1 for those 3 cycles; exactly 2 wr_pop pulses; no phase completes while IRDY=1.
REQ-042 Master abort: DEVSEL held 1 -> ABORT after 4 DATA edges; error and then done pulse; bus released; zero rd_valid/wr_pop; DEVSEL falling on the 4th edge -> no abort.
REQ-043 Reset mid-burst: len=15, RST=1 after the 5th completed phase -> IDLE next cycle; bus released; no done or error; a new req afterward starts a clean address phase.

Source files
------------

// File: rtl/pci_initiator.sv
// PCI bus initiator: one address phase followed by a burst of 1..16 data phases,
// with initiator wait states from the write-data source and a DEVSEL master-abort timeout.
module pci_initiator #(
   parameter logic [3:0] CMD_READ       = 4'b0001,
   parameter logic [3:0] CMD_WRITE      = 4'b0010,
   parameter int         DEVSEL_TIMEOUT = 4
) (
   input  logic        CLK,
   input  logic        RST,
   inout  wire  [31:0] ADDR_DATA,
   output logic [3:0]  C_BE,
   output logic        FRAME,
   output logic        IRDY,
   input  logic        TRDY,
   input  logic        DEVSEL,
   input  logic        req,
   input  logic        req_wr,
   input  logic [31:0] req_addr,
   input  logic [3:0]  req_len,
   input  logic [31:0] wr_data,
   input  logic [3:0]  wr_be,
   input  logic        wr_valid,
   output logic        wr_pop,
   output logic [31:0] rd_data,
   output logic        rd_valid,
   output logic        busy,
   output logic        done,
   output logic        error
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_ADDR  = 3'd1,
      S_DATA  = 3'd2,
      S_ABORT = 3'd3,
      S_TURN  = 3'd4
   } state_t;

   localparam logic [2:0] TMO_LIM = 3'(DEVSEL_TIMEOUT);

   state_t      state_q, state_d;
   logic        wr_q, wr_d;
   logic [31:0] addr_q, addr_d;
   logic [4:0]  rem_q, rem_d;
   logic        seen_q, seen_d;
   logic [2:0]  tmo_q, tmo_d;
   logic [31:0] rd_data_q, rd_data_d;
   logic        rd_valid_q, rd_valid_d;

   logic        ad_oe_s;
   logic [31:0] ad_out_s;
   logic        frame_s, irdy_s, complete_s;
   logic [3:0]  cbe_s;

   assign ADDR_DATA = ad_oe_s ? ad_out_s : 32'hzzzz_zzzz;
   assign FRAME     = frame_s;
   assign IRDY      = irdy_s;
   assign C_BE      = cbe_s;
   assign rd_data   = rd_data_q;
   assign rd_valid  = rd_valid_q;

   // Next-state and bus-drive decode
   always_comb begin
      state_d    = state_q;
      wr_d       = wr_q;
      addr_d     = addr_q;
      rem_d      = rem_q;
      seen_d     = seen_q;
      tmo_d      = tmo_q;
      rd_data_d  = rd_data_q;
      rd_valid_d = 1'b0;
      frame_s    = 1'b1;
      irdy_s     = 1'b1;
      cbe_s      = 4'b0000;
      ad_oe_s    = 1'b0;
      ad_out_s   = 32'h0000_0000;
      complete_s = 1'b0;
      wr_pop     = 1'b0;
      busy       = 1'b1;
      done       = 1'b0;
      error      = 1'b0;
      case (state_q)
         S_IDLE: begin
            busy   = 1'b0;
            seen_d = 1'b0;
            tmo_d  = 3'd0;
            if (req) begin
               wr_d    = req_wr;
               addr_d  = req_addr;
               rem_d   = {1'b0, req_len} + 5'd1;
               state_d = S_ADDR;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_ADDR: begin
            frame_s  = 1'b0;
            cbe_s    = wr_q ? CMD_WRITE : CMD_READ;
            ad_oe_s  = 1'b1;
            ad_out_s = addr_q;
            state_d  = S_DATA;
         end
         S_DATA: begin
            frame_s = (rem_q == 5'd1);
            if (wr_q) begin
               irdy_s   = ~wr_valid;
               cbe_s    = wr_be;
               ad_oe_s  = 1'b1;
               ad_out_s = wr_data;
            end else begin
               irdy_s   = 1'b0;
               cbe_s    = 4'b1111;
            end
            complete_s = ~irdy_s & ~TRDY & ~DEVSEL;
            wr_pop     = complete_s & wr_q;
            if (complete_s) begin
               rem_d = rem_q - 5'd1;
               if (!wr_q) begin
                  rd_data_d  = ADDR_DATA;
                  rd_valid_d = 1'b1;
               end else begin
                  rd_valid_d = 1'b0;
               end
               state_d = (rem_q == 5'd1) ? S_TURN : S_DATA;
            end else begin
               state_d = S_DATA;
            end
            // Timeout only runs until the target has claimed the cycle once
            if (!seen_q) begin
               if (!DEVSEL) begin
                  seen_d = 1'b1;
               end else begin
                  tmo_d = tmo_q + 3'd1;
                  if (tmo_d == TMO_LIM) begin
                     state_d = S_ABORT;
                  end else begin
                     state_d = S_DATA;
                  end
               end
            end else begin
               seen_d = 1'b1;
            end
         end
         S_ABORT: begin
            error   = 1'b1;
            state_d = S_TURN;
         end
         S_TURN: begin
            done    = 1'b1;
            state_d = S_IDLE;
         end
         default: begin
            busy    = 1'b0;
            state_d = S_IDLE;
         end
      endcase
   end

   // State and datapath registers with synchronous reset
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q    <= S_IDLE;
         wr_q       <= 1'b0;
         addr_q     <= 32'h0000_0000;
         rem_q      <= 5'd0;
         seen_q     <= 1'b0;
         tmo_q      <= 3'd0;
         rd_data_q  <= 32'h0000_0000;
         rd_valid_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         wr_q       <= wr_d;
         addr_q     <= addr_d;
         rem_q      <= rem_d;
         seen_q     <= seen_d;
         tmo_q      <= tmo_d;
         rd_data_q  <= rd_data_d;
         rd_valid_q <= rd_valid_d;
      end
   end

endmodule

// File: tb/tb_pci_initiator.sv
// Self-checking bench for pci_initiator: directed bus scenarios plus randomized
// bursts, predicted by a phase-counting transaction model.
module tb_pci_initiator;

   localparam int TMO = 4;

   logic        CLK = 1'b0;
   logic        RST;
   tri1  [31:0] ADDR_DATA;
   logic [3:0]  C_BE;
   logic        FRAME, IRDY, TRDY, DEVSEL;
   logic        req, req_wr;
   logic [31:0] req_addr;
   logic [3:0]  req_len;
   logic [31:0] wr_data;
   logic [3:0]  wr_be;
   logic        wr_valid, wr_pop;
   logic [31:0] rd_data;
   logic        rd_valid, busy, done, error;

   logic        tb_oe;
   logic [31:0] tb_ad;

   int n_checks = 0;
   int n_errors = 0;

   assign ADDR_DATA = tb_oe ? tb_ad : 32'hzzzz_zzzz;

   always #5 CLK = ~CLK;

   pci_initiator #(
      .CMD_READ      (4'b0001),
      .CMD_WRITE     (4'b0010),
      .DEVSEL_TIMEOUT(TMO)
   ) dut (
      .CLK      (CLK),
      .RST      (RST),
      .ADDR_DATA(ADDR_DATA),
      .C_BE     (C_BE),
      .FRAME    (FRAME),
      .IRDY     (IRDY),
      .TRDY     (TRDY),
      .DEVSEL   (DEVSEL),
      .req      (req),
      .req_wr   (req_wr),
      .req_addr (req_addr),
      .req_len  (req_len),
      .wr_data  (wr_data),
      .wr_be    (wr_be),
      .wr_valid (wr_valid),
      .wr_pop   (wr_pop),
      .rd_data  (rd_data),
      .rd_valid (rd_valid),
      .busy     (busy),
      .done     (done),
      .error    (error)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic released();
      return (ADDR_DATA === 32'hFFFF_FFFF) || (ADDR_DATA === 32'hzzzz_zzzz);
   endfunction

   // Bus released and framing idle; done/error/busy as given
   task automatic check_quiet(input string tag, input logic e_done, input logic e_err, input logic e_busy);
      check({tag, ".frame"}, {31'd0, FRAME}, 32'd1);
      check({tag, ".irdy"}, {31'd0, IRDY}, 32'd1);
      check({tag, ".bus_rel"}, {31'd0, released()}, 32'd1);
      check({tag, ".wr_pop"}, {31'd0, wr_pop}, 32'd0);
      check({tag, ".done"}, {31'd0, done}, {31'd0, e_done});
      check({tag, ".error"}, {31'd0, error}, {31'd0, e_err});
      check({tag, ".busy"}, {31'd0, busy}, {31'd0, e_busy});
   endtask

   task automatic check_idle(input string tag);
      check_quiet(tag, 1'b0, 1'b0, 1'b0);
      check({tag, ".cbe"}, {28'd0, C_BE}, 32'd0);
      check({tag, ".rd_valid"}, {31'd0, rd_valid}, 32'd0);
   endtask

   task automatic idle_cycles(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge CLK);
         req = 1'b0; TRDY = 1'b1; DEVSEL = 1'b1; wr_valid = 1'b0; tb_oe = 1'b0;
         #1;
         check_idle("idle_gap");
      end
   endtask

   // One transaction: the model tracks phases left, DATA edges and completions
   task automatic run_txn(input string name, input bit wr, input logic [31:0] addr,
                          input logic [3:0] len, input int dsel_dly,
                          input int trdy_pct, input int wv_pct,
                          input int t_stall_word, input int t_stall_n,
                          input int w_stall_word, input int w_stall_n,
                          input bit seq_rd, input logic [31:0] wd0, input logic [3:0] be0,
                          input int rst_after, input bit hold_req);
      int left, edges, words, stall, budget;
      bit seen, abort, exp_rdv, cpl, dv, tr, wv, irdy_e;
      logic [31:0] exp_rdd, wd, rd_word;
      logic [3:0] be;
      @(negedge CLK);
      req = 1'b1; req_wr = wr; req_addr = addr; req_len = len;
      TRDY = 1'b1; DEVSEL = 1'b1; wr_valid = 1'b0; tb_oe = 1'b0;
      #1;
      check_idle({name, ".pre"});
      @(negedge CLK);
      if (!hold_req) req = 1'b0;
      req_addr = $urandom; req_wr = ~wr; req_len = 4'($urandom);
      #1;
      check({name, ".a_frame"}, {31'd0, FRAME}, 32'd0);
      check({name, ".a_irdy"}, {31'd0, IRDY}, 32'd1);
      check({name, ".a_cbe"}, {28'd0, C_BE}, wr ? 32'h2 : 32'h1);
      check({name, ".a_ad"}, ADDR_DATA, addr);
      check({name, ".a_busy"}, {31'd0, busy}, 32'd1);
      check({name, ".a_pop"}, {31'd0, wr_pop}, 32'd0);
      left = int'(len) + 1; edges = 0; words = 0; stall = 0; budget = 0;
      seen = 1'b0; abort = 1'b0; exp_rdv = 1'b0; exp_rdd = 32'h0;
      while (left > 0 && !abort) begin
         @(negedge CLK);
         if (rst_after >= 0 && words == rst_after) begin
            RST = 1'b1; TRDY = 1'b1; DEVSEL = 1'b1; wr_valid = 1'b0; tb_oe = 1'b0;
            #1;
            check({name, ".r_rdv"}, {31'd0, rd_valid}, {31'd0, exp_rdv});
            @(negedge CLK);
            RST = 1'b0; req = 1'b0;
            #1;
            check_idle({name, ".post_rst"});
            return;
         end
         dv = (edges >= dsel_dly) ? 1'b0 : 1'b1;
         tr = ($urandom_range(99) < trdy_pct) ? 1'b0 : 1'b1;
         if (words == t_stall_word && stall < t_stall_n) tr = 1'b1;
         wv = ($urandom_range(99) < wv_pct);
         if (words == w_stall_word && stall < w_stall_n) wv = 1'b0;
         wd = (words == 0) ? wd0 : $urandom;
         be = (words == 0) ? be0 : 4'($urandom);
         rd_word = seq_rd ? 32'(words + 1) : $urandom;
         TRDY = tr; DEVSEL = dv; wr_valid = wv; wr_data = wd; wr_be = be;
         tb_oe = ~wr; tb_ad = rd_word;
         #1;
         irdy_e = wr ? ~wv : 1'b0;
         cpl = ~irdy_e & ~tr & ~dv;
         check({name, ".d_frame"}, {31'd0, FRAME}, (left == 1) ? 32'd1 : 32'd0);
         check({name, ".d_irdy"}, {31'd0, IRDY}, {31'd0, irdy_e});
         check({name, ".d_cbe"}, {28'd0, C_BE}, wr ? {28'd0, be} : 32'hF);
         check({name, ".d_ad"}, ADDR_DATA, wr ? wd : rd_word);
         check({name, ".d_pop"}, {31'd0, wr_pop}, {31'd0, wr & cpl});
         check({name, ".d_rdv"}, {31'd0, rd_valid}, {31'd0, exp_rdv});
         if (exp_rdv) check({name, ".d_rdd"}, rd_data, exp_rdd);
         check({name, ".d_busy"}, {31'd0, busy}, 32'd1);
         check({name, ".d_flags"}, {30'd0, done, error}, 32'd0);
         @(posedge CLK);
         edges++;
         if (!seen && dv && edges == TMO) abort = 1'b1;
         if (!dv) seen = 1'b1;
         exp_rdv = cpl & ~wr;
         if (cpl) begin
            exp_rdd = rd_word; words++; left--; stall = 0;
         end else begin
            stall++;
         end
         budget++;
         if (budget > 2000) begin
            check({name, ".budget"}, 32'(budget), 32'd2000);
            return;
         end
      end
      @(negedge CLK);
      tb_oe = 1'b0; TRDY = 1'b1; DEVSEL = 1'b1; wr_valid = 1'b0;
      #1;
      if (abort) begin
         check_quiet({name, ".abort"}, 1'b0, 1'b1, 1'b1);
         check({name, ".ab_rdv"}, {31'd0, rd_valid}, 32'd0);
         @(negedge CLK);
         #1;
         exp_rdv = 1'b0;
      end
      check_quiet({name, ".turn"}, 1'b1, 1'b0, 1'b1);
      check({name, ".t_rdv"}, {31'd0, rd_valid}, {31'd0, exp_rdv});
      if (exp_rdv) check({name, ".t_rdd"}, rd_data, exp_rdd);
   endtask

   initial begin
      int dsel_tab [7] = '{0, 0, 1, 2, 3, 4, 6};
      RST = 1'b1; req = 1'b0; req_wr = 1'b0; req_addr = 32'h0; req_len = 4'd0;
      TRDY = 1'b1; DEVSEL = 1'b1; wr_data = 32'h0; wr_be = 4'h0; wr_valid = 1'b0;
      tb_oe = 1'b0; tb_ad = 32'h0;
      repeat (3) @(posedge CLK);
      @(negedge CLK);
      RST = 1'b0;
      #1;
      check_idle("reset");

      run_txn("single_wr", 1'b1, 32'h0000_0000, 4'd0, 0, 100, 100, -1, 0, -1, 0,
              1'b0, 32'hDEAD_BEEF, 4'hF, -1, 1'b0);
      idle_cycles(1);
      run_txn("rd_burst", 1'b0, 32'h1000_0040, 4'd3, 0, 100, 100, 2, 2, -1, 0,
              1'b1, 32'h0, 4'h0, -1, 1'b0);
      idle_cycles(1);
      run_txn("wr_stall", 1'b1, 32'h2000_0000, 4'd1, 0, 100, 100, -1, 0, 1, 3,
              1'b0, 32'h1234_5678, 4'h3, -1, 1'b0);
      idle_cycles(1);
      run_txn("abort_rd", 1'b0, 32'h3000_0000, 4'd2, 100, 100, 100, -1, 0, -1, 0,
              1'b0, 32'h0, 4'h0, -1, 1'b0);
      idle_cycles(1);
      run_txn("abort_wr", 1'b1, 32'h3000_1000, 4'd5, 100, 100, 50, -1, 0, -1, 0,
              1'b0, 32'hCAFE_0001, 4'h5, -1, 1'b0);
      idle_cycles(1);
      run_txn("late_dsel", 1'b0, 32'h3000_2000, 4'd1, TMO - 1, 100, 100, -1, 0, -1, 0,
              1'b1, 32'h0, 4'h0, -1, 1'b0);
      idle_cycles(1);
      run_txn("rst_mid", 1'b0, 32'h4000_0000, 4'd15, 0, 100, 100, -1, 0, -1, 0,
              1'b1, 32'h0, 4'h0, 5, 1'b0);
      idle_cycles(2);
      run_txn("post_rst", 1'b1, 32'h5000_0000, 4'd0, 0, 100, 100, -1, 0, -1, 0,
              1'b0, 32'h0BAD_F00D, 4'hA, -1, 1'b0);
      run_txn("hold_a", 1'b1, 32'h6000_0000, 4'd1, 0, 100, 100, -1, 0, -1, 0,
              1'b0, 32'h1111_2222, 4'hC, -1, 1'b1);
      run_txn("hold_b", 1'b0, 32'h6000_0100, 4'd0, 1, 100, 100, -1, 0, -1, 0,
              1'b1, 32'h0, 4'h0, -1, 1'b0);
      idle_cycles(1);

      for (int t = 0; t < 40; t++) begin
         run_txn("rand", 1'($urandom), $urandom, 4'($urandom),
                 dsel_tab[$urandom_range(6)], int'($urandom_range(100, 40)),
                 int'($urandom_range(100, 40)), -1, 0, -1, 0, 1'b0, $urandom,
                 4'($urandom), -1, 1'b0);
         idle_cycles(int'($urandom_range(2, 1)));
      end

      idle_cycles(2);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
